// File: rtl/mem_pkg.sv
// mem_pkg
//   Shared definitions for the memory-stage load/store engine:
//   RV32I funct3 access encodings, FSM state type, byte-enable
//   constants and a legality helper used by mem_access_unit.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_H0   = 4'b0011;
  localparam logic [3:0] BE_H1   = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  // Stores have no unsigned variants, so only the plain B/H/W codes are legal.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align
//   Combinational load formatter: picks the addressed byte or halfword
//   out of the returned memory word and sign/zero extends it.
//   Ports:
//     rdata   in  32  word returned by data memory
//     addr_lo in  2   low byte-address bits of the load
//     funct3  in  3   RV32I load size/sign encoding
//     data    out 32  extended load result
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[7:0];
    case (addr_lo)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
      default: sel_byte = rdata[7:0];
    endcase
    sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   data = {24'b0, sel_byte};
      F3_H:    data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   data = {16'b0, sel_half};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage load/store engine. Accepts the E->M register outputs,
//   runs one req/ack transaction on the data-memory port per access,
//   steers store bytes, formats load data and stalls the upstream
//   pipeline until the access finishes. Misaligned accesses, illegal
//   funct3 codes and a missing ack all produce a one-cycle fault pulse.
//   Ports:
//     clk, rst          clock / synchronous active-high reset
//     m_aluresult       effective byte address
//     m_writedata       store data
//     m_memread/write   load / store present in M
//     m_funct3          access size and sign
//     m_regwrite        regwrite from E->M register
//     m_regwrite_gated  regwrite to W, suppressed while stalled/faulted
//     m_readdata        extended load data to W
//     m_stall           hold PC/F/D/E/M registers
//     m_fault           one-cycle fault pulse
//     dmem_req/we/addr/wdata/be  registered memory request
//     dmem_rdata/ack    memory response
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] m_aluresult,
  input  logic [DATA_WIDTH-1:0]    m_writedata,
  input  logic                     m_memread,
  input  logic                     m_memwrite,
  input  logic [2:0]               m_funct3,
  input  logic                     m_regwrite,
  output logic                     m_regwrite_gated,
  output logic [DATA_WIDTH-1:0]    m_readdata,
  output logic                     m_stall,
  output logic                     m_fault,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  output logic [3:0]               dmem_be,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  input  logic                     dmem_ack
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t    state_q;
  logic [CW-1:0] wait_cnt_q;
  logic [1:0]    addr_lo_q;
  logic [2:0]    funct3_q;

  logic                  access;
  logic                  legal;
  logic                  aligned;
  logic                  start_ok;
  logic                  start_bad;
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [3:0]            st_be;
  logic [31:0]           load_data;

  // Classify the access presented in M: both read and write together is
  // treated as illegal, otherwise funct3 legality depends on direction.
  always_comb begin
    access  = m_memread | m_memwrite;
    legal   = !(m_memread && m_memwrite) && f3_legal(m_funct3, m_memwrite);
    aligned = 1'b1;
    case (m_funct3[1:0])
      2'b10:   aligned = (m_aluresult[1:0] == 2'b00);
      2'b01:   aligned = (m_aluresult[0] == 1'b0);
      default: aligned = 1'b1;
    endcase
    start_ok    = (state_q == IDLE) && access && legal && aligned;
    start_bad   = (state_q == IDLE) && access && !(legal && aligned);
    timeout_hit = (state_q == WAIT) && !dmem_ack &&
                  (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  end

  // Store lane steering: data is replicated across lanes so memory only
  // needs the byte enables to pick the right bytes.
  always_comb begin
    st_wdata = m_writedata;
    st_be    = BE_ALL;
    case (m_funct3[1:0])
      2'b00: begin
        st_wdata = {4{m_writedata[7:0]}};
        st_be    = BE_B0 << m_aluresult[1:0];
      end
      2'b01: begin
        st_wdata = {2{m_writedata[15:0]}};
        st_be    = m_aluresult[1] ? BE_H1 : BE_H0;
      end
      default: begin
        st_wdata = m_writedata;
        st_be    = BE_ALL;
      end
    endcase
  end

  // Load formatting uses the latched low address bits and funct3 so the
  // result does not depend on M inputs staying stable during WAIT.
  load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .data    (load_data)
  );

  // Pipeline-facing outputs. Faulting accesses and timeouts release the
  // stall but suppress regwrite so the instruction retires as a bubble.
  always_comb begin
    m_stall          = 1'b0;
    m_regwrite_gated = 1'b0;
    m_readdata       = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (!access) begin
            m_regwrite_gated = m_regwrite;
          end else if (start_ok) begin
            m_stall = 1'b1;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            m_regwrite_gated = m_regwrite;
            m_readdata       = dmem_we ? '0 : load_data;
          end else if (!timeout_hit) begin
            m_stall = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM, request registers, wait counter and fault pulse. A late ack in
  // IDLE falls through without effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      addr_lo_q  <= 2'b00;
      funct3_q   <= 3'b000;
      m_fault    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= BE_NONE;
    end else begin
      m_fault <= start_bad || timeout_hit;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q    <= WAIT;
            wait_cnt_q <= '0;
            addr_lo_q  <= m_aluresult[1:0];
            funct3_q   <= m_funct3;
            dmem_req   <= 1'b1;
            dmem_we    <= m_memwrite;
            dmem_addr  <= {m_aluresult[ADDRESS_WIDTH-1:2], 2'b00};
            dmem_wdata <= m_memwrite ? st_wdata : '0;
            dmem_be    <= st_be;
          end
        end
        WAIT: begin
          if (dmem_ack || timeout_hit) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= BE_NONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
